bank_access_ctrl: RTL and testbench

- Initiator side of the Bank storage model: turns ACT/RD/WR/PRE commands into per-beat row/column/rd_o_wr/dq traffic on one Bank instance.
- Tracks the open cached row, sequences fixed-length bursts with in-block column wrap, and returns read beats aligned to the Bank's read latency.
- Sits between the command decoder and each Bank instance.

---
 rtl/bank_access_ctrl_if.sv | 29 ++
 rtl/bank_access_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bank_access_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_access_ctrl_if.sv
// Command/data channel between the command decoder and bank_access_ctrl.
// The decoder side uses the master modport; the controller uses slave.
interface bank_access_ctrl_if #(
   parameter int DEVICE_WIDTH = 4,
   parameter int COLWIDTH     = 10,
   parameter int CHWIDTH      = 5
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic [CHWIDTH-1:0]      cmd_row;
   logic [COLWIDTH-1:0]     cmd_col;
   logic [DEVICE_WIDTH-1:0] wr_data;
   logic                    wr_beat;
   logic [DEVICE_WIDTH-1:0] rd_data;
   logic                    rd_valid;
   logic                    cmd_err;
   logic                    row_open;

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_col, wr_data,
      input  cmd_ready, wr_beat, rd_data, rd_valid, cmd_err, row_open
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_col, wr_data,
      output cmd_ready, wr_beat, rd_data, rd_valid, cmd_err, row_open
   );
endinterface

// File: rtl/bank_access_ctrl.sv
// Initiator for one Bank instance: turns ACT/RD/WR/PRE commands into
// per-beat row/column/write-enable traffic. Bursts are BL beats long and
// wrap inside the BL-aligned column block. Read beats come back through a
// valid pipeline matched to the Bank read latency.
module bank_access_ctrl #(
   parameter int DEVICE_WIDTH = 4,
   parameter int COLWIDTH     = 10,
   parameter int CHWIDTH      = 5,
   parameter int BLWIDTH      = 3,
   parameter int RD_LAT       = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   bank_access_ctrl_if.slave       cmd_if,
   output logic                    bank_rd_o_wr,
   output logic [DEVICE_WIDTH-1:0] bank_dqin,
   output logic [CHWIDTH-1:0]      bank_row,
   output logic [COLWIDTH-1:0]     bank_column,
   input  logic [DEVICE_WIDTH-1:0] bank_dqout
);

   localparam logic [1:0] OP_ACT = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_WR  = 2'd2;
   localparam logic [1:0] OP_PRE = 2'd3;

   localparam logic [BLWIDTH-1:0] LAST_BEAT = '1;
   localparam logic [BLWIDTH-1:0] BEAT_ONE  = BLWIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_RBURST,
      ST_WBURST
   } state_t;

   state_t                 state_q, state_d;
   logic [CHWIDTH-1:0]     row_q, row_d;
   logic [COLWIDTH-1:0]    col_q, col_d;
   logic [BLWIDTH-1:0]     beat_q, beat_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   row_open_q, row_open_d;
   logic                   cmd_err_q, cmd_err_d;
   logic [RD_LAT-1:0]      rd_vld_q, rd_vld_d;

   logic                   accept;
   logic                   last_beat;
   logic                   in_wburst;
   logic                   in_rburst;

   assign accept    = cmd_if.cmd_valid && cmd_ready_q;
   assign last_beat = (beat_q == LAST_BEAT);
   assign in_wburst = (state_q == ST_WBURST);
   assign in_rburst = (state_q == ST_RBURST);

   // Next-state, open-row, burst address and handshake computation.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      beat_d    = beat_q;
      cmd_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_if.cmd_op)
                  OP_ACT: begin
                     row_d   = cmd_if.cmd_row;
                     state_d = ST_ACTIVE;
                  end
                  OP_PRE: begin
                     // Precharging a closed bank is harmless.
                     state_d = ST_IDLE;
                  end
                  default: begin
                     // RD/WR with no open row: drop the command.
                     cmd_err_d = 1'b1;
                  end
               endcase
            end
         end

         ST_ACTIVE: begin
            if (accept) begin
               case (cmd_if.cmd_op)
                  OP_RD: begin
                     col_d   = cmd_if.cmd_col;
                     beat_d  = '0;
                     state_d = ST_RBURST;
                  end
                  OP_WR: begin
                     col_d   = cmd_if.cmd_col;
                     beat_d  = '0;
                     state_d = ST_WBURST;
                  end
                  OP_PRE: begin
                     state_d = ST_IDLE;
                  end
                  default: begin
                     // ACT on an already open bank keeps the current row.
                     cmd_err_d = 1'b1;
                  end
               endcase
            end
         end

         ST_RBURST, ST_WBURST: begin
            if (last_beat) begin
               // Column stays on the final beat address after the burst.
               state_d = ST_ACTIVE;
            end else begin
               beat_d = beat_q + BEAT_ONE;
               // Increment only the low BLWIDTH bits so the address wraps
               // inside the aligned block without carrying upward.
               col_d  = {col_q[COLWIDTH-1:BLWIDTH],
                         col_q[BLWIDTH-1:0] + BEAT_ONE};
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
      row_open_d  = (state_d != ST_IDLE);
   end

   // Controller state and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         beat_q      <= '0;
         cmd_ready_q <= 1'b1;
         row_open_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         beat_q      <= beat_d;
         cmd_ready_q <= cmd_ready_d;
         row_open_q  <= row_open_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   // Read-valid shift chain: stage 0 marks a read beat issued last cycle,
   // the final stage lines up with Bank data.
   assign rd_vld_d[0] = in_rburst;
   generate
      for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
         assign rd_vld_d[gi] = rd_vld_q[gi-1];
      end
   endgenerate

   // Read-valid pipeline runs independently of the FSM; reset flushes it
   // so beats issued before reset never surface.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_vld_q <= '0;
      end else begin
         rd_vld_q <= rd_vld_d;
      end
   end

   assign cmd_if.cmd_ready = cmd_ready_q;
   assign cmd_if.row_open  = row_open_q;
   assign cmd_if.cmd_err   = cmd_err_q;
   assign cmd_if.wr_beat   = in_wburst;
   assign cmd_if.rd_valid  = rd_vld_q[RD_LAT-1];
   assign cmd_if.rd_data   = rd_vld_q[RD_LAT-1] ? bank_dqout : '0;

   assign bank_rd_o_wr = in_wburst;
   assign bank_dqin    = in_wburst ? cmd_if.wr_data : '0;
   assign bank_row     = row_q;
   assign bank_column  = col_q;

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Self-checking bench for bank_access_ctrl: a behavioural Bank model plus
// a reference of expected memory contents and command legality.
module tb_bank_access_ctrl;

   localparam int DW     = 4;
   localparam int CW     = 10;
   localparam int RW     = 5;
   localparam int BLW    = 3;
   localparam int BL     = 8;
   localparam int RD_LAT = 2;

   localparam int OP_ACT = 0;
   localparam int OP_RD  = 1;
   localparam int OP_WR  = 2;
   localparam int OP_PRE = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          bank_rd_o_wr;
   logic [DW-1:0] bank_dqin;
   logic [DW-1:0] bank_dqout;
   logic [RW-1:0] bank_row;
   logic [CW-1:0] bank_column;

   bank_access_ctrl_if #(.DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW)) u_if ();

   bank_access_ctrl #(
      .DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW),
      .BLWIDTH(BLW), .RD_LAT(RD_LAT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_if       (u_if.slave),
      .bank_rd_o_wr (bank_rd_o_wr),
      .bank_dqin    (bank_dqin),
      .bank_row     (bank_row),
      .bank_column  (bank_column),
      .bank_dqout   (bank_dqout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: write on edge, read data RD_LAT cycles after the address.
   logic [DW-1:0] bank_mem [0:31][0:1023];
   logic [DW-1:0] dq_pipe [0:RD_LAT-1];
   initial begin
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 1024; c++)
            bank_mem[r][c] = '0;
      for (int i = 0; i < RD_LAT; i++) dq_pipe[i] = '0;
   end
   always @(posedge clk) begin
      if (bank_rd_o_wr === 1'b1) bank_mem[bank_row][bank_column] <= bank_dqin;
      dq_pipe[0] <= bank_mem[bank_row][bank_column];
      for (int i = 1; i < RD_LAT; i++) dq_pipe[i] <= dq_pipe[i-1];
   end
   assign bank_dqout = dq_pipe[RD_LAT-1];

   // Collected read beats with their cycle stamps.
   logic [DW-1:0] rdq_data [$];
   int            rdq_cyc  [$];
   always @(negedge clk) begin
      if (u_if.rd_valid === 1'b1) begin
         rdq_data.push_back(u_if.rd_data);
         rdq_cyc.push_back(cyc);
      end
   end

   // Reference model.
   logic [DW-1:0] ref_mem [int];
   bit            ref_open = 1'b0;
   int            ref_row  = 0;
   logic [DW-1:0] wdata [0:BL-1];

   int checks = 0;
   int errors = 0;

   function automatic int exp_col(input int col, input int k);
      return (col / BL) * BL + ((col % BL) + k) % BL;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input int row, input int col);
      int key;
      key = row * 1024 + col;
      if (ref_mem.exists(key)) return ref_mem[key];
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a command and hold it until accepted (bounded).
   task automatic send(input int op, input int row, input int col);
      bit ok;
      ok = 1'b0;
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = 2'(op);
      u_if.cmd_row   = RW'(row);
      u_if.cmd_col   = CW'(col);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (u_if.cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_ready_wait", u_if.cmd_ready, 1);
      @(posedge clk); #1;
      u_if.cmd_valid = 1'b0;
   endtask

   // Issue one command and check all of its consequences.
   task automatic exec(input int op, input int row, input int col);
      bit            legal;
      logic [DW-1:0] ed [BL];
      int            ec [BL];
      legal = (op == OP_PRE) || (op == OP_ACT && !ref_open) ||
              ((op == OP_RD || op == OP_WR) && ref_open);
      $display("txn cyc=%0d op=%0d row=%0d col=%03h legal=%0d", cyc, op, row, col, legal);
      send(op, row, col);
      if (!legal) begin
         @(negedge clk);
         chk("err_pulse", u_if.cmd_err, 1);
         chk("err_no_wr", bank_rd_o_wr, 0);
         chk("err_no_beat", u_if.wr_beat, 0);
         chk("err_row_open", u_if.row_open, ref_open);
         if (ref_open) chk("err_row_kept", bank_row, ref_row);
         @(posedge clk); #1;
         @(negedge clk);
         chk("err_one_cycle", u_if.cmd_err, 0);
         @(posedge clk); #1;
      end else if (op == OP_ACT) begin
         @(negedge clk);
         chk("act_row_open", u_if.row_open, 1);
         chk("act_row", bank_row, row);
         chk("act_no_err", u_if.cmd_err, 0);
         chk("act_ready", u_if.cmd_ready, 1);
         ref_open = 1'b1;
         ref_row  = row;
         @(posedge clk); #1;
      end else if (op == OP_PRE) begin
         @(negedge clk);
         chk("pre_row_closed", u_if.row_open, 0);
         chk("pre_no_err", u_if.cmd_err, 0);
         chk("pre_ready", u_if.cmd_ready, 1);
         ref_open = 1'b0;
         @(posedge clk); #1;
      end else if (op == OP_WR) begin
         for (int k = 0; k < BL; k++) begin
            u_if.wr_data = wdata[k];
            @(negedge clk);
            chk("wr_beat", u_if.wr_beat, 1);
            chk("wr_en", bank_rd_o_wr, 1);
            chk("wr_col", bank_column, exp_col(col, k));
            chk("wr_row", bank_row, ref_row);
            chk("wr_dq", bank_dqin, wdata[k]);
            chk("wr_busy", u_if.cmd_ready, 0);
            ref_mem[ref_row * 1024 + exp_col(col, k)] = wdata[k];
            @(posedge clk); #1;
         end
         u_if.wr_data = '0;
         @(negedge clk);
         chk("wr_done_ready", u_if.cmd_ready, 1);
         chk("wr_done_beat", u_if.wr_beat, 0);
         @(posedge clk); #1;
      end else begin
         rdq_data.delete();
         rdq_cyc.delete();
         for (int k = 0; k < BL; k++) begin
            @(negedge clk);
            chk("rd_col", bank_column, exp_col(col, k));
            chk("rd_row", bank_row, ref_row);
            chk("rd_no_wr", bank_rd_o_wr, 0);
            chk("rd_no_beat", u_if.wr_beat, 0);
            chk("rd_busy", u_if.cmd_ready, 0);
            ed[k] = ref_rd(ref_row, exp_col(col, k));
            ec[k] = cyc + RD_LAT;
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk("rd_done_ready", u_if.cmd_ready, 1);
         repeat (RD_LAT + 2) @(posedge clk);
         #1;
         chk("rd_count", rdq_data.size(), BL);
         for (int k = 0; k < BL && k < rdq_data.size(); k++) begin
            chk("rd_data", rdq_data[k], ed[k]);
            chk("rd_lat", rdq_cyc[k], ec[k]);
         end
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int            acc [3];
      int            nacc;
      int            nready;
      int            c1, c2;
      logic [DW-1:0] bd [2*BL];
      int            bc [2*BL];

      u_if.cmd_valid = 1'b0;
      u_if.cmd_op    = '0;
      u_if.cmd_row   = '0;
      u_if.cmd_col   = '0;
      u_if.wr_data   = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_cmd_ready", u_if.cmd_ready, 1);
      chk("rst_row_open", u_if.row_open, 0);
      chk("rst_rd_valid", u_if.rd_valid, 0);
      chk("rst_rd_data", u_if.rd_data, 0);
      chk("rst_cmd_err", u_if.cmd_err, 0);
      chk("rst_wr_beat", u_if.wr_beat, 0);
      chk("rst_bank_wr", bank_rd_o_wr, 0);
      chk("rst_bank_dqin", bank_dqin, 0);
      chk("rst_bank_row", bank_row, 0);
      chk("rst_bank_col", bank_column, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Basic write then read of a block starting at column 0.
      exec(OP_ACT, 5, 0);
      for (int k = 0; k < BL; k++) wdata[k] = DW'(k);
      exec(OP_WR, 0, 'h000);
      exec(OP_RD, 0, 'h000);

      // Wrap inside the top block of the column space.
      exec(OP_PRE, 0, 0);
      exec(OP_ACT, 3, 0);
      wdata[0] = 4'hA; wdata[1] = 4'hB; wdata[2] = 4'hC; wdata[3] = 4'hD;
      wdata[4] = 4'hE; wdata[5] = 4'hF; wdata[6] = 4'h1; wdata[7] = 4'h2;
      exec(OP_WR, 0, 'h3FD);
      exec(OP_RD, 0, 'h3F8);

      // Illegal and no-op commands.
      exec(OP_PRE, 0, 0);
      exec(OP_RD, 0, 'h010);
      exec(OP_ACT, 7, 0);
      exec(OP_ACT, 2, 0);
      exec(OP_PRE, 0, 0);
      exec(OP_PRE, 0, 0);

      // Row isolation at the same column.
      for (int k = 0; k < BL; k++) wdata[k] = DW'($urandom);
      wdata[0] = 4'h9;
      exec(OP_ACT, 1, 0);
      exec(OP_WR, 0, 4);
      exec(OP_PRE, 0, 0);
      wdata[0] = 4'h6;
      exec(OP_ACT, 2, 0);
      exec(OP_WR, 0, 4);
      exec(OP_PRE, 0, 0);
      exec(OP_ACT, 1, 0);
      exec(OP_RD, 0, 4);
      exec(OP_PRE, 0, 0);
      exec(OP_ACT, 2, 0);
      exec(OP_RD, 0, 4);
      exec(OP_PRE, 0, 0);

      // Reset at beat 3 of a read burst.
      exec(OP_ACT, 4, 0);
      $display("txn cyc=%0d reset during read burst", cyc);
      send(OP_RD, 0, 'h010);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      rdq_data.delete();
      rdq_cyc.delete();
      ref_open = 1'b0;
      @(negedge clk);
      chk("midrst_ready", u_if.cmd_ready, 1);
      chk("midrst_row_open", u_if.row_open, 0);
      chk("midrst_bank_wr", bank_rd_o_wr, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_rd_valid", rdq_data.size(), 0);
      exec(OP_RD, 0, 'h010);

      // Back-to-back reads with cmd_valid held, then PRE right behind.
      exec(OP_ACT, 6, 0);
      c1 = 'h020;
      c2 = 'h035;
      for (int k = 0; k < BL; k++) wdata[k] = DW'($urandom);
      exec(OP_WR, 0, c1);
      for (int k = 0; k < BL; k++) wdata[k] = DW'($urandom);
      exec(OP_WR, 0, c2);
      $display("txn cyc=%0d back-to-back RD %03h, RD %03h, PRE", cyc, c1, c2);
      rdq_data.delete();
      rdq_cyc.delete();
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      nacc = 0;
      nready = 0;
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = 2'(OP_RD);
      u_if.cmd_col   = CW'(c1);
      for (int n = 0; n < 60 && nacc < 3; n++) begin
         @(negedge clk);
         if (u_if.cmd_ready === 1'b1) begin
            if (nacc == 1) nready++;
            acc[nacc] = cyc;
            nacc++;
         end
         @(posedge clk); #1;
         if (nacc == 1) u_if.cmd_col = CW'(c2);
         else if (nacc == 2) u_if.cmd_op = 2'(OP_PRE);
         else if (nacc == 3) u_if.cmd_valid = 1'b0;
      end
      u_if.cmd_valid = 1'b0;
      ref_open = 1'b0;
      for (int k = 0; k < BL; k++) begin
         bd[k]      = ref_rd(6, exp_col(c1, k));
         bc[k]      = acc[0] + 1 + k + RD_LAT;
         bd[BL + k] = ref_rd(6, exp_col(c2, k));
         bc[BL + k] = acc[1] + 1 + k + RD_LAT;
      end
      chk("b2b_accepts", nacc, 3);
      chk("b2b_ready_cycles", nready, 1);
      chk("b2b_spacing_rd", acc[1] - acc[0], BL + 1);
      chk("b2b_spacing_pre", acc[2] - acc[1], BL + 1);
      repeat (RD_LAT + 3) @(posedge clk);
      #1;
      chk("b2b_row_closed", u_if.row_open, 0);
      chk("b2b_rd_count", rdq_data.size(), 2 * BL);
      for (int k = 0; k < 2 * BL && k < rdq_data.size(); k++) begin
         chk("b2b_rd_data", rdq_data[k], bd[k]);
         chk("b2b_rd_lat", rdq_cyc[k], bc[k]);
      end

      // Randomized command stream against the reference model.
      for (int t = 0; t < 40; t++) begin
         int op, row, col;
         op  = int'($urandom_range(0, 3));
         row = int'($urandom_range(0, 3));
         col = int'($urandom_range(0, 1023));
         for (int k = 0; k < BL; k++) wdata[k] = DW'($urandom);
         exec(op, row, col);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
